fp_mul_pipe: RTL and testbench

- Parametrised, pipelined IEEE-754-style floating-point multiplier.
- Successor to the combinational fp_mul:
  - configurable exponent and mantissa widths
  - 3-stage pipeline with valid/ready handshake on both sides
  - selectable rounding mode, exception flags, and a passthrough tag
- Sits between operand sources (e.g. an MAC/vector datapath) and any consumer that may apply backpressure.

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_mul_round.sv | 84 ++++++++
 rtl/fp_mul_pipe.sv | 167 ++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point multiplier pipeline: operand
// classes, exception flag bit positions and format helper functions.
package fp_pkg;

    // Operand / special-case class carried down the pipeline
    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_cls_e;

    // Bit positions inside the 4-bit flag vector {invalid, overflow, underflow, inexact}
    localparam int unsigned FLAG_W         = 4;
    localparam int unsigned FLAG_INVALID   = 3;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_INEXACT   = 0;

    // Exponent bias for an exponent field of exp_w bits
    function automatic int unsigned exp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    // Canonical quiet NaN (sign 0, exponent all ones, only mantissa MSB set),
    // returned right-aligned in 64 bits; callers truncate to their width.
    function automatic logic [63:0] canon_nan(input int unsigned exp_w, input int unsigned man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 32'd1));
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Normalise, round and pack stage of the multiplier (combinational).
// Ports:
//   prod_i       significand product (1.ma)*(1.mb), 2*MAN_W+2 bits
//   exp_i        signed biased exponent sum before normalisation
//   sign_i       result sign
//   rnd_mode_i   0 = round-to-nearest-even, 1 = round-toward-zero
//   cls_i        special-case class resolved from both operands
//   res_c_o      packed result {sign, exp, man}
//   flags_c_o    {invalid, overflow, underflow, inexact}
module fp_mul_round
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [2*MAN_W+1:0]         prod_i,
    input  logic signed [EXP_W+1:0]    exp_i,
    input  logic                       sign_i,
    input  logic                       rnd_mode_i,
    input  fp_cls_e                    cls_i,
    output logic [EXP_W+MAN_W:0]       res_c_o,
    output logic [FLAG_W-1:0]          flags_c_o
);

    localparam int unsigned PROD_W = 2 * MAN_W + 2;
    localparam int unsigned DATA_W = 1 + EXP_W + MAN_W;
    localparam int unsigned XW     = EXP_W + 2;

    localparam logic signed [XW-1:0] EXP_MAX  = XW'((32'd1 << EXP_W) - 32'd1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;

    logic [PROD_W-1:0]       norm;
    logic signed [XW-1:0]    exp_n;
    logic signed [XW-1:0]    exp_r;
    logic [MAN_W-1:0]        man;
    logic                    guard;
    logic                    sticky;
    logic                    inc;
    logic [MAN_W:0]          man_r;

    // Normalise so the hidden bit sits at the product MSB, then round
    always_comb begin
        norm   = prod_i[PROD_W-1] ? prod_i : (prod_i << 1);
        exp_n  = prod_i[PROD_W-1] ? (exp_i + XW'(1)) : exp_i;
        man    = norm[PROD_W-2 -: MAN_W];
        guard  = norm[PROD_W-2-MAN_W];
        sticky = |norm[PROD_W-3-MAN_W:0];
        inc    = !rnd_mode_i && guard && (sticky || man[0]);
        // A carry out of the mantissa leaves the low MAN_W bits all zero
        man_r  = {1'b0, man} + (MAN_W+1)'(inc);
        exp_r  = exp_n + XW'(man_r[MAN_W]);
    end

    // Special-case selection and packing, highest priority first
    always_comb begin
        res_c_o                 = {sign_i, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
        flags_c_o               = '0;
        flags_c_o[FLAG_INEXACT] = guard || sticky;
        if (cls_i == CLS_NAN) begin
            res_c_o                 = DATA_W'(canon_nan(EXP_W, MAN_W));
            flags_c_o               = '0;
            flags_c_o[FLAG_INVALID] = 1'b1;
        end else if (cls_i == CLS_INF) begin
            res_c_o   = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_c_o = '0;
        end else if (cls_i == CLS_ZERO) begin
            res_c_o   = {sign_i, {(DATA_W-1){1'b0}}};
            flags_c_o = '0;
        end else if (exp_r >= EXP_MAX) begin
            res_c_o = rnd_mode_i ? {sign_i, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                                 : {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_c_o                = '0;
            flags_c_o[FLAG_OVERFLOW] = 1'b1;
            flags_c_o[FLAG_INEXACT]  = 1'b1;
        end else if (exp_n <= EXP_ZERO) begin
            // Flush-to-zero decided on the normalised, unrounded exponent
            res_c_o                   = {sign_i, {(DATA_W-1){1'b0}}};
            flags_c_o                 = '0;
            flags_c_o[FLAG_UNDERFLOW] = 1'b1;
            flags_c_o[FLAG_INEXACT]   = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready on both
// sides, selectable rounding, exception flags and a passthrough tag.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   i_valid / o_ready      input handshake (o_ready is the global enable)
//   i_data_a, i_data_b     operands {sign, exp, man}
//   i_rnd_mode             0 = RNE, 1 = RTZ, sampled with the operands
//   i_tag                  user tag returned with the result
//   o_valid / i_ready      output handshake
//   fp_mul_o, o_flags      product and {invalid, overflow, underflow, inexact}
//   o_tag                  tag of the presented result
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MAN_W  = 23,
    parameter int unsigned DATA_W = 1 + EXP_W + MAN_W,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [DATA_W-1:0]   i_data_a,
    input  logic [DATA_W-1:0]   i_data_b,
    input  logic                i_rnd_mode,
    input  logic [TAG_W-1:0]    i_tag,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_W-1:0]   fp_mul_o,
    output logic [FLAG_W-1:0]   o_flags,
    output logic [TAG_W-1:0]    o_tag
);

    if (DATA_W != 1 + EXP_W + MAN_W) begin : g_bad_data_w
        $error("fp_mul_pipe: DATA_W must equal 1+EXP_W+MAN_W");
    end

    localparam int unsigned SIG_W  = MAN_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned XW     = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS_X = XW'(exp_bias(EXP_W));

    // Classify one operand; subnormals collapse into zero
    function automatic fp_cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0)                   return CLS_ZERO;
        else if (e == {EXP_W{1'b1}})   return (m == '0) ? CLS_INF : CLS_NAN;
        else                           return CLS_NORM;
    endfunction

    logic en;

    // Stage 1 registers
    logic                    s1_valid_q;
    logic                    s1_sign_q,  s1_sign_d;
    logic signed [XW-1:0]    s1_exp_q,   s1_exp_d;
    logic [SIG_W-1:0]        s1_sig_a_q, s1_sig_b_q;
    fp_cls_e                 s1_cls_q,   s1_cls_d;
    logic                    s1_rnd_q;
    logic [TAG_W-1:0]        s1_tag_q;

    // Stage 2 registers
    logic                    s2_valid_q;
    logic                    s2_sign_q;
    logic signed [XW-1:0]    s2_exp_q;
    logic [PROD_W-1:0]       s2_prod_q,  s2_prod_d;
    fp_cls_e                 s2_cls_q;
    logic                    s2_rnd_q;
    logic [TAG_W-1:0]        s2_tag_q;

    // Output stage registers
    logic                    out_valid_q;
    logic [DATA_W-1:0]       out_res_q,   out_res_d;
    logic [FLAG_W-1:0]       out_flags_q, out_flags_d;
    logic [TAG_W-1:0]        out_tag_q;

    fp_cls_e cls_a, cls_b;

    // All stages move together unless a presented result is being held
    assign en      = !out_valid_q || i_ready;
    assign o_ready = en;

    // Unpack: class resolution, sign and biased exponent sum
    always_comb begin
        cls_a     = classify(i_data_a[DATA_W-2 -: EXP_W], i_data_a[MAN_W-1:0]);
        cls_b     = classify(i_data_b[DATA_W-2 -: EXP_W], i_data_b[MAN_W-1:0]);
        s1_sign_d = i_data_a[DATA_W-1] ^ i_data_b[DATA_W-1];
        s1_exp_d  = XW'(i_data_a[DATA_W-2 -: EXP_W]) + XW'(i_data_b[DATA_W-2 -: EXP_W]) - BIAS_X;
        s1_cls_d  = CLS_NORM;
        if ((cls_a == CLS_NAN) || (cls_b == CLS_NAN) ||
            ((cls_a == CLS_INF) && (cls_b == CLS_ZERO)) ||
            ((cls_a == CLS_ZERO) && (cls_b == CLS_INF))) begin
            s1_cls_d = CLS_NAN;
        end else if ((cls_a == CLS_INF) || (cls_b == CLS_INF)) begin
            s1_cls_d = CLS_INF;
        end else if ((cls_a == CLS_ZERO) || (cls_b == CLS_ZERO)) begin
            s1_cls_d = CLS_ZERO;
        end
    end

    // Significand product
    assign s2_prod_d = PROD_W'(s1_sig_a_q) * PROD_W'(s1_sig_b_q);

    fp_mul_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .prod_i     (s2_prod_q),
        .exp_i      (s2_exp_q),
        .sign_i     (s2_sign_q),
        .rnd_mode_i (s2_rnd_q),
        .cls_i      (s2_cls_q),
        .res_c_o    (out_res_d),
        .flags_c_o  (out_flags_d)
    );

    // Pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_sig_a_q  <= '0;
            s1_sig_b_q  <= '0;
            s1_cls_q    <= CLS_ZERO;
            s1_rnd_q    <= 1'b0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= '0;
            s2_prod_q   <= '0;
            s2_cls_q    <= CLS_ZERO;
            s2_rnd_q    <= 1'b0;
            s2_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_flags_q <= '0;
            out_tag_q   <= '0;
        end else if (en) begin
            s1_valid_q  <= i_valid;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_sig_a_q  <= {1'b1, i_data_a[MAN_W-1:0]};
            s1_sig_b_q  <= {1'b1, i_data_b[MAN_W-1:0]};
            s1_cls_q    <= s1_cls_d;
            s1_rnd_q    <= i_rnd_mode;
            s1_tag_q    <= i_tag;
            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s1_sign_q;
            s2_exp_q    <= s1_exp_q;
            s2_prod_q   <= s2_prod_d;
            s2_cls_q    <= s1_cls_q;
            s2_rnd_q    <= s1_rnd_q;
            s2_tag_q    <= s1_tag_q;
            out_valid_q <= s2_valid_q;
            out_res_q   <= out_res_d;
            out_flags_q <= out_flags_d;
            out_tag_q   <= s2_tag_q;
        end
    end

    assign o_valid  = out_valid_q;
    assign fp_mul_o = out_res_q;
    assign o_flags  = out_flags_q;
    assign o_tag    = out_tag_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (binary32 configuration).
module tb_fp_mul_pipe;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data_a;
    logic [31:0] i_data_b;
    logic        i_rnd_mode;
    logic [3:0]  i_tag;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] fp_mul_o;
    logic [3:0]  o_flags;
    logic [3:0]  o_tag;

    int checks   = 0;
    int failures = 0;

    fp_mul_pipe #(
        .EXP_W  (8),
        .MAN_W  (23),
        .DATA_W (32),
        .TAG_W  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data_a   (i_data_a),
        .i_data_b   (i_data_b),
        .i_rnd_mode (i_rnd_mode),
        .i_tag      (i_tag),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .fp_mul_o   (fp_mul_o),
        .o_flags    (o_flags),
        .o_tag      (o_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference multiply: exact integer product, round by remainder vs. half-ulp
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b, input logic rtz,
                                    output logic [31:0] r, output logic [3:0] f);
        int ea, eb, e, sh;
        logic s;
        bit za, zb, ia, ib, na, nb;
        longint unsigned p, q, rem, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        f  = 4'b0000;
        if (na || nb || (ia && zb) || (ib && za)) begin
            r = 32'h7FC0_0000;
            f = 4'b1000;
        end else if (ia || ib) begin
            r = {s, 8'hFF, 23'h0};
        end else if (za || zb) begin
            r = {s, 31'h0};
        end else begin
            p  = (64'h80_0000 + 64'(a[22:0])) * (64'h80_0000 + 64'(b[22:0]));
            sh = (p >= (64'd1 << 47)) ? 24 : 23;
            e  = ea + eb - 127 + (sh - 23);
            q  = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (e <= 0) begin
                r = {s, 31'h0};
                f = 4'b0011;
            end else begin
                if (rem != 0) f[0] = 1'b1;
                if (!rtz && ((rem > half) || ((rem == half) && q[0]))) q = q + 1;
                if (q == (64'd1 << 24)) begin
                    q = q >> 1;
                    e = e + 1;
                end
                if (e >= 255) begin
                    f = 4'b0101;
                    r = rtz ? {s, 8'hFE, 23'h7FFFFF} : {s, 8'hFF, 23'h0};
                end else begin
                    r = {s, 8'(e), 23'(q)};
                end
            end
        end
    endfunction

    // Mostly mid-range normals, with a mix of specials and range extremes
    function automatic logic [31:0] rand_operand();
        int unsigned k;
        logic [31:0] v;
        k = $urandom_range(0, 19);
        v = $urandom;
        case (k)
            0: v[30:0] = '0;
            1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
            2: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
            3: begin v[30:23] = 8'h00; v[0] = 1'b1; end
            4: v[30:23] = 8'($urandom_range(200, 254));
            5: v[30:23] = 8'($urandom_range(1, 40));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // Drives one operation into an empty pipeline and captures its result
    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic rtz,
                           input logic [3:0] tag, output logic [31:0] r,
                           output logic [3:0] f, output logic [3:0] t, output int lat);
        i_ready    = 1'b1;
        i_data_a   = a;
        i_data_b   = b;
        i_rnd_mode = rtz;
        i_tag      = tag;
        i_valid    = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat     = 1;
        while (!o_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = fp_mul_o;
        f = o_flags;
        t = o_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        i_data_a = '0;
        i_data_b = '0;
        i_rnd_mode = 1'b0;
        i_tag    = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
        checks++;
        if (fp_mul_o !== 32'h0) begin failures++; $display("FAIL reset_fp_mul_o got=%h exp=0", fp_mul_o); end
        checks++;
        if (o_flags !== 4'h0) begin failures++; $display("FAIL reset_o_flags got=%b exp=0000", o_flags); end
        checks++;
        if (o_tag !== 4'h0) begin failures++; $display("FAIL reset_o_tag got=%h exp=0", o_tag); end
        rst = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_o_ready got=%b exp=1", o_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] va[11] = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h7F800000, 32'hFF800000,
                                32'h7F000000, 32'h7F000000, 32'h00800000, 32'h80000001, 32'h7FC00001,
                                32'h40000000};
        logic [31:0] vb[11] = '{32'h40000000, 32'h3F800001, 32'h3F800001, 32'h00000000, 32'h40000000,
                                32'h40000000, 32'h40000000, 32'h00800000, 32'h3F800000, 32'h3F800000,
                                32'hC0400000};
        logic        vr[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] er[11] = '{32'h40400000, 32'h3F800002, 32'h3F800002, 32'h7FC00000, 32'hFF800000,
                                32'h7F800000, 32'h7F7FFFFF, 32'h00000000, 32'h80000000, 32'h7FC00000,
                                32'hC0C00000};
        logic [3:0]  ef[11] = '{4'b0000, 4'b0001, 4'b0001, 4'b1000, 4'b0000,
                                4'b0101, 4'b0101, 4'b0011, 4'b0000, 4'b1000, 4'b0000};
        logic [31:0] r;
        logic [3:0]  f, t;
        int          lat;
        for (int i = 0; i < 11; i++) begin
            run_one(va[i], vb[i], vr[i], 4'(i + 3), r, f, t, lat);
            checks++;
            if (lat != 3) begin failures++; $display("FAIL directed_latency[%0d] got=%0d exp=3", i, lat); end
            checks++;
            if (r !== er[i]) begin failures++; $display("FAIL directed_result[%0d] got=%h exp=%h", i, r, er[i]); end
            checks++;
            if (f !== ef[i]) begin failures++; $display("FAIL directed_flags[%0d] got=%b exp=%b", i, f, ef[i]); end
            checks++;
            if (t !== 4'(i + 3)) begin failures++; $display("FAIL directed_tag[%0d] got=%h exp=%h", i, t, 4'(i + 3)); end
        end
    endtask

    // Streams n random ops; with bp set, i_ready and i_valid follow random patterns
    task automatic test_stream(input int n, input bit bp, input string name);
        logic [31:0] qr[$];
        logic [3:0]  qf[$];
        logic [3:0]  qt[$];
        logic [31:0] hr, er, xr;
        logic [3:0]  hf, ht, ef, xf, xt;
        int          issued = 0;
        int          got = 0;
        int          cyc = 0;
        bit          have = 0;
        bit          held = 0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        while ((got < n) && (cyc < 600)) begin
            @(posedge clk); #1;
            cyc++;
            if (!have && (issued < n) && (!bp || ($urandom_range(0, 3) != 0))) begin
                i_data_a   = rand_operand();
                i_data_b   = rand_operand();
                i_rnd_mode = 1'($urandom_range(0, 1));
                i_tag      = 4'(issued);
                have       = 1'b1;
                issued++;
            end
            i_valid = have;
            i_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (held) begin
                checks++;
                if (!(o_valid === 1'b1 && fp_mul_o === hr && o_flags === hf && o_tag === ht)) begin
                    failures++;
                    $display("FAIL %s_hold got=%b/%h/%b/%h exp=1/%h/%b/%h",
                             name, o_valid, fp_mul_o, o_flags, o_tag, hr, hf, ht);
                end
            end
            if (i_valid && o_ready) begin
                ref_mul(i_data_a, i_data_b, i_rnd_mode, er, ef);
                qr.push_back(er);
                qf.push_back(ef);
                qt.push_back(i_tag);
                have = 1'b0;
            end
            if (o_valid && i_ready) begin
                checks++;
                if (qr.size() == 0) begin
                    failures++;
                    $display("FAIL %s_unexpected got=%h exp=none", name, fp_mul_o);
                end else begin
                    xr = qr.pop_front();
                    xf = qf.pop_front();
                    xt = qt.pop_front();
                    if (fp_mul_o !== xr) begin failures++; $display("FAIL %s_result[%0d] got=%h exp=%h", name, got, fp_mul_o, xr); end
                    checks++;
                    if (o_flags !== xf) begin failures++; $display("FAIL %s_flags[%0d] got=%b exp=%b", name, got, o_flags, xf); end
                    checks++;
                    if (o_tag !== xt) begin failures++; $display("FAIL %s_tag[%0d] got=%h exp=%h", name, got, o_tag, xt); end
                end
                got++;
            end
            held = o_valid && !i_ready;
            hr   = fp_mul_o;
            hf   = o_flags;
            ht   = o_tag;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        checks++;
        if ((got != n) || (qr.size() != 0)) begin
            failures++;
            $display("FAIL %s_count got=%0d pending=%0d exp=%0d pending=0", name, got, qr.size(), n);
        end
    endtask

    task automatic test_reset_midflight();
        bit          seen = 0;
        logic [31:0] r;
        logic [3:0]  f, t;
        int          lat;
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data_a   = 32'h3FC00000;
            i_data_b   = 32'h40000000;
            i_rnd_mode = 1'b0;
            i_tag      = 4'(9 + i);
            i_valid    = 1'b1;
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        rst     = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL midreset_o_valid got=%b exp=0", o_valid); end
        checks++;
        if (fp_mul_o !== 32'h0) begin failures++; $display("FAIL midreset_fp_mul_o got=%h exp=0", fp_mul_o); end
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (o_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL midreset_stale got=1 exp=0"); end
        run_one(32'h40400000, 32'h40400000, 1'b0, 4'hE, r, f, t, lat);
        checks++;
        if ((lat != 3) || (r !== 32'h41100000) || (t !== 4'hE)) begin
            failures++;
            $display("FAIL midreset_recover got=%0d/%h/%h exp=3/41100000/e", lat, r, t);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_stream(40, 1'b0, "back_to_back");
        test_stream(10, 1'b1, "backpressure");
        test_stream(30, 1'b1, "random_bp");
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
